tone_detector: RTL

- Receive-side counterpart of the square-wave tone generator.
- Measures the half-period of an incoming square wave in prescaled tick units, giving an 11-bit value.
- Returns that value as nibbles through the same LSEL/HSEL/HHSEL select scheme the generator uses for writes, so software can read a tone back in the generator's own units.
- Sits beside the tone generator on the 4-bit host data bus. Typical use is loopback self-test or pitch detection on an external input.

---
 rtl/tone_detector_if.sv | 11 +
 rtl/tone_detector.sv | 119 +++++++++++
 2 files changed

// File: rtl/tone_detector_if.sv
// Host read port of the tone detector: three nibble selects and the 4-bit read data.
// LSEL returns the live low nibble and latches a snapshot; HSEL/HHSEL read that snapshot.
interface tone_detector_if;
    logic       LSEL;
    logic       HSEL;
    logic       HHSEL;
    logic [3:0] DOUT;

    modport master (output LSEL, output HSEL, output HHSEL, input DOUT);
    modport slave  (input LSEL, input HSEL, input HHSEL, output DOUT);
endinterface

// File: rtl/tone_detector.sv
// Measures the half-period of an asynchronous square wave in TICK units and returns
// it as nibbles using the tone generator's LSEL/HSEL/HHSEL layout.
module tone_detector #(
    parameter int WIDTH       = 11,
    parameter int MIN_COUNT   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic            CLK,
    input  logic            RST_C,
    input  logic            TICK,
    input  logic            SIN,
    tone_detector_if.slave  bus,
    output logic            VALID,
    output logic            NOSIG,
    output logic            NEWR,
    output logic [0:0]      state_dbg
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ARMED = 1'b1;
    localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_COUNT);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [0:0]             state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       snap_q, snap_d;
    logic                   valid_q, valid_d;
    logic                   nosig_q, nosig_d;
    logic                   newr_q, newr_d;

    logic                   edge_det;
    logic                   cnt_max;
    logic                   accept;
    logic [3:0]             dout;

    assign edge_det = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign cnt_max  = &cnt_q;
    // Out of IDLE any edge only re-arms; in ARMED short intervals are glitches.
    assign accept   = edge_det && ((state_q == ST_IDLE) || (cnt_q >= MIN_CNT));

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], SIN};
        prev_d   = sync_q[SYNC_STAGES-1];
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        valid_d  = valid_q;
        nosig_d  = nosig_q;
        newr_d   = 1'b0;
        snap_d   = bus.LSEL ? result_q : snap_q;

        if (accept) begin
            cnt_d   = '0;
            state_d = ST_ARMED;
            if (state_q == ST_ARMED) begin
                result_d = cnt_q;
                newr_d   = 1'b1;
                valid_d  = 1'b1;
                nosig_d  = 1'b0;
            end
        end else begin
            if (TICK && !cnt_max) begin
                cnt_d = cnt_q + ONE;
            end
            // Saturated counter with no accepted edge: the signal is gone.
            if (cnt_max) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                nosig_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST_C) begin
        if (RST_C) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            snap_q   <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b0;
            newr_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            snap_q   <= snap_d;
            valid_q  <= valid_d;
            nosig_q  <= nosig_d;
            newr_q   <= newr_d;
        end
    end

    // The low nibble is live; upper nibbles come from the snapshot taken on the L read.
    always_comb begin
        dout = 4'd0;
        if (bus.LSEL) begin
            dout = result_q[3:0];
        end else if (bus.HSEL) begin
            dout = snap_q[7:4];
        end else if (bus.HHSEL) begin
            dout = {1'b0, snap_q[WIDTH-1:8]};
        end
    end

    assign bus.DOUT  = dout;
    assign VALID     = valid_q;
    assign NOSIG     = nosig_q;
    assign NEWR      = newr_q;
    assign state_dbg = state_q;

endmodule
